// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types for the decode/issue control slice: issue bundle layout,
// register-count helper and squash-cause encoding.
package decode_issue_ctrl_pkg;

    // Id width used by issue_bundle_t. The top defaults REG_ID_W to this value;
    // any override of REG_ID_W must change this value to the same width.
    localparam int unsigned ISSUE_ID_W = 6;

    function automatic int unsigned num_regs(input int unsigned id_w);
        return 32'd1 << id_w;
    endfunction

    localparam int unsigned NUM_REGS = num_regs(ISSUE_ID_W);

    typedef struct packed {
        logic [ISSUE_ID_W-1:0] rd_id;
        logic                  rd_we;
        logic [ISSUE_ID_W-1:0] rs1_id;
        logic [ISSUE_ID_W-1:0] rs2_id;
        logic                  resolve;
        logic                  select_target_pc;
        logic                  squash_after_j;
        logic                  squash_after_jalr;
    } issue_bundle_t;

    typedef enum logic [1:0] {
        SQ_NONE,
        SQ_J,
        SQ_JALR
    } squash_cause_e;

endpackage

// File: rtl/decode_issue_ctrl_scoreboard.sv
// Pending-write scoreboard and RAW/WAW hazard compare for decode_issue_ctrl.
module decode_scoreboard
    import decode_issue_ctrl_pkg::*;
#(
    parameter int unsigned REG_ID_W = ISSUE_ID_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                set_i,
    input  logic [REG_ID_W-1:0] set_id_i,
    input  logic                wb_valid_i,
    input  logic [REG_ID_W-1:0] wb_rd_id_i,
    input  logic                iss_valid_i,
    input  logic                iss_rd_we_i,
    input  logic [REG_ID_W-1:0] iss_rd_id_i,
    input  logic                dec_valid_i,
    input  logic                dec_rd_we_i,
    input  logic [REG_ID_W-1:0] dec_rd_id_i,
    input  logic [REG_ID_W-1:0] dec_rs1_id_i,
    input  logic [REG_ID_W-1:0] dec_rs2_id_i,
    output logic                hazard_o
);

    localparam int unsigned NREGS = num_regs(REG_ID_W);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] eff_pending;
    logic             iss_rd_live;
    logic             hit_rs1;
    logic             hit_rs2;
    logic             hit_rd;

    // Set is applied after clear so a same-cycle issue and writeback of one id leaves it pending.
    always_comb begin
        clr_vec = '0;
        if (wb_valid_i) begin
            clr_vec[wb_rd_id_i] = 1'b1;
        end
        eff_pending = pending_q & ~clr_vec;
        pending_d   = eff_pending;
        if (set_i && (set_id_i != '0)) begin
            pending_d[set_id_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        iss_rd_live = iss_valid_i && iss_rd_we_i;
        hit_rs1 = (dec_rs1_id_i != '0) &&
                  (eff_pending[dec_rs1_id_i] || (iss_rd_live && (iss_rd_id_i == dec_rs1_id_i)));
        hit_rs2 = (dec_rs2_id_i != '0) &&
                  (eff_pending[dec_rs2_id_i] || (iss_rd_live && (iss_rd_id_i == dec_rs2_id_i)));
        hit_rd  = (dec_rd_id_i != '0) &&
                  (eff_pending[dec_rd_id_i] || (iss_rd_live && (iss_rd_id_i == dec_rd_id_i)));
        hazard_o = dec_valid_i && (hit_rs1 || hit_rs2 || (dec_rd_we_i && hit_rd));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-to-execute issue register with scoreboard stalls and J/JALR wrong-path squash.
// Optional stall counter output enabled by DECODE_ISSUE_STALL_CNT_EN.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int unsigned REG_ID_W          = ISSUE_ID_W,
    parameter int unsigned SQUASH_J_SLOTS    = 1,
    parameter int unsigned SQUASH_JALR_SLOTS = 2,
    parameter int unsigned CNT_W             = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  logic [REG_ID_W-1:0] dec_rd_id,
    input  logic                dec_rd_we,
    input  logic [REG_ID_W-1:0] dec_rs1_id,
    input  logic [REG_ID_W-1:0] dec_rs2_id,
    input  logic                dec_resolve,
    input  logic                dec_select_target_pc,
    input  logic                dec_squash_after_j,
    input  logic                dec_squash_after_jalr,
    output logic                iss_valid,
    input  logic                iss_ready,
    output logic [REG_ID_W-1:0] iss_rd_id,
    output logic                iss_rd_we,
    output logic [REG_ID_W-1:0] iss_rs1_id,
    output logic [REG_ID_W-1:0] iss_rs2_id,
    output logic                iss_resolve,
    output logic                iss_select_target_pc,
    output logic                iss_squash_after_j,
    output logic                iss_squash_after_jalr,
    input  logic                wb_valid,
    input  logic [REG_ID_W-1:0] wb_rd_id,
    input  logic                ex_flush
`ifdef DECODE_ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    issue_bundle_t  iss_q, iss_d, dec_bundle;
    logic           iss_valid_q, iss_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cause_slots;
    logic [0:0]     state;
    squash_cause_e  cause;
    logic           hazard;
    logic           adv;
    logic           accept;
    logic           load;
    logic           iss_fire;

    always_comb begin
        state     = (cnt_q != '0) ? ST_SQUASH : ST_NORMAL;
        adv       = !iss_valid_q || iss_ready;
        dec_ready = !rst && !ex_flush && ((state == ST_SQUASH) || (adv && !hazard));
        accept    = dec_valid && dec_ready;
        load      = accept && (state == ST_NORMAL);
        // A flushed issue-register entry is killed, so it neither sets pending nor starts a squash.
        iss_fire  = iss_valid_q && iss_ready && !ex_flush;
    end

    always_comb begin
        dec_bundle                   = '0;
        dec_bundle.rd_id             = dec_rd_id;
        dec_bundle.rd_we             = dec_rd_we;
        dec_bundle.rs1_id            = dec_rs1_id;
        dec_bundle.rs2_id            = dec_rs2_id;
        dec_bundle.resolve           = dec_resolve;
        dec_bundle.select_target_pc  = dec_select_target_pc;
        dec_bundle.squash_after_j    = dec_squash_after_j;
        dec_bundle.squash_after_jalr = dec_squash_after_jalr;
    end

    always_comb begin
        iss_d       = iss_q;
        iss_valid_d = iss_valid_q;
        if (ex_flush) begin
            iss_valid_d = 1'b0;
        end else if (load) begin
            iss_d       = dec_bundle;
            iss_valid_d = 1'b1;
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end
    end

    always_comb begin
        cause = SQ_NONE;
        if (iss_fire) begin
            if (iss_q.squash_after_jalr) begin
                cause = SQ_JALR;
            end else if (iss_q.squash_after_j) begin
                cause = SQ_J;
            end
        end
        case (cause)
            SQ_JALR: cause_slots = CNT_W'(SQUASH_JALR_SLOTS);
            SQ_J:    cause_slots = CNT_W'(SQUASH_J_SLOTS);
            default: cause_slots = '0;
        endcase
        cnt_d = cnt_q;
        if (ex_flush) begin
            cnt_d = '0;
        end else if (cause_slots != '0) begin
            cnt_d = cause_slots;
        end else if (accept && (state == ST_SQUASH)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_q       <= '0;
            iss_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            iss_q       <= iss_d;
            iss_valid_q <= iss_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    decode_scoreboard #(
        .REG_ID_W (REG_ID_W)
    ) u_scoreboard (
        .clk_i        (clk),
        .rst_i        (rst),
        .set_i        (iss_fire && iss_q.rd_we),
        .set_id_i     (iss_q.rd_id),
        .wb_valid_i   (wb_valid),
        .wb_rd_id_i   (wb_rd_id),
        .iss_valid_i  (iss_valid_q),
        .iss_rd_we_i  (iss_q.rd_we),
        .iss_rd_id_i  (iss_q.rd_id),
        .dec_valid_i  (dec_valid),
        .dec_rd_we_i  (dec_rd_we),
        .dec_rd_id_i  (dec_rd_id),
        .dec_rs1_id_i (dec_rs1_id),
        .dec_rs2_id_i (dec_rs2_id),
        .hazard_o     (hazard)
    );

    assign iss_valid             = iss_valid_q;
    assign iss_rd_id             = iss_q.rd_id;
    assign iss_rd_we             = iss_q.rd_we;
    assign iss_rs1_id            = iss_q.rs1_id;
    assign iss_rs2_id            = iss_q.rs2_id;
    assign iss_resolve           = iss_q.resolve;
    assign iss_select_target_pc  = iss_q.select_target_pc;
    assign iss_squash_after_j    = iss_q.squash_after_j;
    assign iss_squash_after_jalr = iss_q.squash_after_jalr;

`ifdef DECODE_ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (dec_valid && !dec_ready && !ex_flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
